ir_queue: RTL and testbench

Parametrised instruction register with a prefetch queue. It sits between the MBR and the control unit. Instruction bytes arrive from `MBR_IN` one at a time under the control-word load bit, are packed into full instructions (opcode byte first), and are held in a DEPTH-entry FIFO. The head entry is presented as opcode plus operand until the control unit pops it, which lets fetch run ahead of execute.

---
 rtl/ir_queue.sv | 108 ++++++++++
 tb/tb_ir_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ir_queue.sv
// Instruction register with prefetch FIFO: packs MBR bytes into instructions
// (opcode byte first) and presents the head entry until the control unit pops it.
module ir_queue #(
  parameter int unsigned BYTE_W      = 8,
  parameter int unsigned INSTR_BYTES = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned LOAD_BIT    = 4,
  parameter int unsigned POP_BIT     = 5,
  parameter int unsigned FLUSH_BIT   = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [31:0]                         control_signal,
  input  logic [BYTE_W-1:0]                   MBR_IN,
  output logic [BYTE_W-1:0]                   IR_OUT,
  output logic [(INSTR_BYTES-1)*BYTE_W-1:0]   OPERAND_OUT,
  output logic                                IR_VALID,
  output logic                                IR_FULL,
  output logic [$clog2(DEPTH):0]              IR_COUNT,
  output logic                                ASM_BUSY,
  output logic                                IR_OVF
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BC_W   = $clog2(INSTR_BYTES);
  localparam int unsigned OPR_W  = (INSTR_BYTES - 1) * BYTE_W;
  localparam int unsigned WORD_W = INSTR_BYTES * BYTE_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [BC_W-1:0]   byte_cnt_q;
  logic [OPR_W-1:0]  asm_q;
  logic              ovf_q;

  logic load, pop, flush;
  logic final_byte, fifo_full, fifo_empty;
  logic do_pop, do_push, drop;
  logic [WORD_W-1:0] head;
  logic unused_ctrl;

  assign load  = control_signal[LOAD_BIT];
  assign pop   = control_signal[POP_BIT];
  assign flush = control_signal[FLUSH_BIT];
  assign unused_ctrl = ^control_signal;

  // Decode of this cycle's queue actions; a pop frees the slot for a same-cycle push.
  always_comb begin
    final_byte = (byte_cnt_q == BC_W'(INSTR_BYTES - 1));
    fifo_full  = (count_q == CNT_W'(DEPTH));
    fifo_empty = (count_q == '0);
    do_pop     = pop && !fifo_empty;
    do_push    = load && final_byte && (!fifo_full || do_pop);
    drop       = load && final_byte && fifo_full && !do_pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      ovf_q      <= 1'b0;
    end else if (flush) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      byte_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (load && !final_byte) begin
        byte_cnt_q <= byte_cnt_q + BC_W'(1);
        for (int unsigned k = 0; k < INSTR_BYTES - 1; k++) begin
          if (byte_cnt_q == BC_W'(k)) asm_q[OPR_W-1-k*BYTE_W -: BYTE_W] <= MBR_IN;
        end
      end else if (do_push) begin
        byte_cnt_q <= '0;
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem_q[wr_ptr_q] <= {asm_q, MBR_IN};
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    IR_VALID    = !fifo_empty;
    IR_FULL     = fifo_full;
    IR_COUNT    = count_q;
    ASM_BUSY    = (byte_cnt_q != '0);
    IR_OVF      = ovf_q;
    IR_OUT      = fifo_empty ? '0 : head[WORD_W-1 -: BYTE_W];
    OPERAND_OUT = fifo_empty ? '0 : head[OPR_W-1:0];
  end

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue: default instance checked against a spec-level
// scoreboard, plus a 3-byte / 2-entry instance for the parameter corner.
module tb_ir_queue;

  logic        clk;
  logic        rst, rst_b;
  logic [31:0] cs, cs_b;
  logic [7:0]  mbr, mbr_b;

  logic [7:0]  ir_out, ir_out_b;
  logic [7:0]  opr_out;
  logic [15:0] opr_out_b;
  logic        ir_valid, ir_full, asm_busy, ir_ovf;
  logic        ir_valid_b, ir_full_b, asm_busy_b, ir_ovf_b;
  logic [2:0]  ir_count;
  logic [1:0]  ir_count_b;

  int vectors;
  int miscompares;

  // Scoreboard / model for the default instance
  logic [15:0] sb[$];
  int          mbc;
  logic [7:0]  mslot;
  logic        movf;

  ir_queue dut (
    .clk(clk), .rst(rst), .control_signal(cs), .MBR_IN(mbr),
    .IR_OUT(ir_out), .OPERAND_OUT(opr_out), .IR_VALID(ir_valid),
    .IR_FULL(ir_full), .IR_COUNT(ir_count), .ASM_BUSY(asm_busy), .IR_OVF(ir_ovf)
  );

  ir_queue #(.INSTR_BYTES(3), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .control_signal(cs_b), .MBR_IN(mbr_b),
    .IR_OUT(ir_out_b), .OPERAND_OUT(opr_out_b), .IR_VALID(ir_valid_b),
    .IR_FULL(ir_full_b), .IR_COUNT(ir_count_b), .ASM_BUSY(asm_busy_b), .IR_OVF(ir_ovf_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [15:0] h;
    h = (sb.size() != 0) ? sb[0] : 16'h0;
    check({tag, ".ir"},    32'(ir_out),   32'(h[15:8]));
    check({tag, ".opr"},   32'(opr_out),  32'(h[7:0]));
    check({tag, ".count"}, 32'(ir_count), 32'(sb.size()));
    check({tag, ".valid"}, 32'(ir_valid), 32'(sb.size() != 0));
    check({tag, ".full"},  32'(ir_full),  32'(sb.size() == 4));
    check({tag, ".busy"},  32'(asm_busy), 32'(mbc != 0));
    check({tag, ".ovf"},   32'(ir_ovf),   32'(movf));
  endtask

  // One clock on the default instance; the scoreboard follows the spec rules.
  task automatic step(input logic r, input logic l, input logic p, input logic f,
                      input logic [7:0] b);
    int  sz;
    logic dpop;
    cs = 32'($urandom) & ~32'h0000_0070;
    cs[4] = l; cs[5] = p; cs[6] = f;
    rst = r; mbr = b;
    @(posedge clk);
    if (r) begin
      sb.delete(); mbc = 0; movf = 1'b0;
    end else if (f) begin
      sb.delete(); mbc = 0; movf = 1'b0;
    end else begin
      sz   = sb.size();
      dpop = p && (sz > 0);
      if (dpop) void'(sb.pop_front());
      if (l) begin
        if (mbc == 0) begin
          mslot = b; mbc = 1;
        end else if (sz < 4 || dpop) begin
          sb.push_back({mslot, b}); mbc = 0;
        end else begin
          movf = 1'b1;
        end
      end
    end
    #1;
    rst = 1'b0; cs = '0;
  endtask

  task automatic step_b(input logic r, input logic l, input logic [7:0] b);
    cs_b = '0; cs_b[4] = l; rst_b = r; mbr_b = b;
    @(posedge clk);
    #1;
    rst_b = 1'b0; cs_b = '0;
  endtask

  initial begin
    clk = 1'b0; vectors = 0; miscompares = 0;
    rst = 1'b0; cs = '0; mbr = '0; rst_b = 1'b0; cs_b = '0; mbr_b = '0;
    mbc = 0; mslot = '0; movf = 1'b0;

    // Reset, then two bytes
    step(1, 0, 0, 0, 8'h00);
    check_state("reset");
    check("reset.count0", 32'(ir_count), 32'd0);
    step(0, 1, 0, 0, 8'h12);
    check("fill1.busy", 32'(asm_busy), 32'd1);
    check("fill1.valid", 32'(ir_valid), 32'd0);
    step(0, 1, 0, 0, 8'h34);
    check("fill2.ir", 32'(ir_out), 32'h12);
    check("fill2.opr", 32'(opr_out), 32'h34);
    check("fill2.count", 32'(ir_count), 32'd1);
    check("fill2.busy", 32'(asm_busy), 32'd0);
    step(0, 0, 1, 0, 8'h00);
    check_state("drain");

    // Fill to full, then overflow
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 8'hA0 + 8'(i));
      step(0, 1, 0, 0, 8'h01 + 8'(i));
    end
    check_state("full");
    check("full.flag", 32'(ir_full), 32'd1);
    check("full.count", 32'(ir_count), 32'd4);
    step(0, 1, 0, 0, 8'hA4);
    check("ovf.partial_busy", 32'(asm_busy), 32'd1);
    step(0, 1, 0, 0, 8'h05);
    check_state("ovf");
    check("ovf.flag", 32'(ir_ovf), 32'd1);
    check("ovf.head", 32'({ir_out, opr_out}), 32'hA001);

    // Push and pop together on a full queue
    step(0, 1, 1, 0, 8'h05);
    check_state("pushpop");
    check("pushpop.head", 32'({ir_out, opr_out}), 32'hA102);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 8'h00);
      check_state("popwrap");
    end
    check("wrap.head", 32'({ir_out, opr_out}), 32'hA405);
    step(0, 0, 1, 0, 8'h00);
    check_state("lastpop");

    // Pop on empty is ignored
    step(0, 0, 1, 0, 8'h00);
    check_state("popempty");
    check("popempty.ir", 32'(ir_out), 32'd0);
    step(0, 1, 0, 0, 8'h77);
    step(0, 1, 0, 0, 8'h88);
    check("refill.head", 32'({ir_out, opr_out}), 32'h7788);

    // Flush wins over load and pop
    step(0, 1, 0, 0, 8'h99);
    step(0, 1, 0, 0, 8'hAA);
    step(0, 1, 0, 0, 8'hBB);
    check("preflush.count", 32'(ir_count), 32'd2);
    step(0, 1, 1, 1, 8'hCC);
    check_state("flush");
    check("flush.count", 32'(ir_count), 32'd0);
    check("flush.busy", 32'(asm_busy), 32'd0);
    check("flush.ovf", 32'(ir_ovf), 32'd0);
    check("flush.ir", 32'(ir_out), 32'd0);

    // Mixed traffic against the scoreboard
    for (int i = 0; i < 60; i++) begin
      step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 29) == 0), 8'($urandom));
      check_state("mix");
    end

    // Reset mid-assembly discards the byte loaded with it
    step(0, 0, 0, 1, 8'h00);
    step(0, 1, 0, 0, 8'h5A);
    step(1, 1, 0, 0, 8'h6B);
    check_state("midrst");

    // 3-byte, 2-entry instance
    step_b(1, 0, 8'h00);
    check("b.reset.count", 32'(ir_count_b), 32'd0);
    step_b(0, 1, 8'h11);
    step_b(0, 1, 8'h22);
    check("b.partial.valid", 32'(ir_valid_b), 32'd0);
    step_b(0, 1, 8'h33);
    check("b.ir", 32'(ir_out_b), 32'h11);
    check("b.opr", 32'(opr_out_b), 32'h2233);
    check("b.count", 32'(ir_count_b), 32'd1);
    step_b(0, 1, 8'h44);
    check("b.busy", 32'(asm_busy_b), 32'd1);
    step_b(1, 1, 8'h55);
    check("b.rst.all", 32'({ir_out_b, opr_out_b, ir_valid_b, ir_full_b,
                            ir_count_b, asm_busy_b, ir_ovf_b}), 32'd0);
    for (int i = 1; i <= 9; i++) step_b(0, 1, 8'(i));
    check("b.full", 32'(ir_full_b), 32'd1);
    check("b.ovf", 32'(ir_ovf_b), 32'd1);
    check("b.ovf.busy", 32'(asm_busy_b), 32'd1);
    check("b.head", 32'({ir_out_b, opr_out_b}), 32'h010203);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
